sys_run_ctrl: RTL and testbench

Parametrised run-control and debug-display block for the simplified MIPS computer; sits between the board I/O (keys, switches, LEDs, 7-segment digits) and the CPU core. Conditions the load and step keys and runs a HALT/STEP/RUN/LOAD state machine. The machine drives the CPU clock-enable and PC-load strobes. It snapshots one selected debug channel and drives it to a configurable number of hex digits and LEDs.

---
 rtl/sys_ctrl_pkg.sv | 24 ++
 rtl/sys_debounce.sv | 42 ++++
 rtl/sys_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_sys_run_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the run-control block: one-hot FSM states,
// active-low 7-segment patterns and the hex decode helper.
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_HALT = 4'b0001,
    ST_STEP = 4'b0010,
    ST_LOAD = 4'b0100,
    ST_RUN  = 4'b1000
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Element n is the active-low gfedcba pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_hex(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/sys_debounce.sv
// Debouncer: the output follows the input only after DEB_CYCLES consecutive
// samples that differ from the current stable level.
module sys_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic out_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (in_i != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = in_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign out_o = stable_q;

endmodule

// File: rtl/sys_run_ctrl.sv
// Run-control and debug display: key conditioning, HALT/STEP/LOAD/RUN FSM,
// debug channel snapshot to hex digits. Define SYS_DEBOUNCE_EN to debounce keys.
module sys_run_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned PC_W       = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned SEL_W      = 8,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned RUN_DIV    = 1,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic                     SYS_clk,
  input  logic                     SYS_rst,
  input  logic                     SYS_load,
  input  logic                     SYS_step,
  input  logic                     SYS_run,
  input  logic [PC_W-1:0]          SYS_pc_val,
  input  logic [SEL_W-1:0]         SYS_output_sel,
  input  logic [NUM_CH*DATA_W-1:0] SYS_dbg,
  output logic                     SYS_cpu_en,
  output logic                     SYS_pc_load,
  output logic [PC_W-1:0]          SYS_pc_load_val,
  output logic [7:0]               SYS_leds,
  output logic [NUM_DIGITS*7-1:0]  SYS_hex
);

  localparam int unsigned CNT_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_DIV - 1);
  localparam int unsigned EXT_W = NUM_DIGITS * 4 + DATA_W;

  // Bit order in the key pipeline: {run, step, load}.
  logic [2:0]        sync1_q, sync2_q;
  logic              load_lvl, step_lvl, run_lvl;
  logic [1:0]        prev_q, pulse_q;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_en_q, cpu_en_d, pc_load_q, pc_load_d;
  logic [PC_W-1:0]   pc_val_q, pc_val_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic              sel_err_q, sel_err_d;
  logic [EXT_W-1:0]  snap_ext;

`ifdef SYS_DEBOUNCE_EN
  sys_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk_i(SYS_clk), .rst_i(SYS_rst), .in_i(sync2_q[0]), .out_o(load_lvl)
  );
  sys_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk_i(SYS_clk), .rst_i(SYS_rst), .in_i(sync2_q[1]), .out_o(step_lvl)
  );
`else
  assign load_lvl = sync2_q[0];
  assign step_lvl = sync2_q[1];
`endif
  assign run_lvl = sync2_q[2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    cpu_en_d  = 1'b0;
    pc_load_d = 1'b0;
    pc_val_d  = pc_val_q;
    unique case (state_q)
      ST_HALT: begin
        if (pulse_q[0])      state_d = ST_LOAD;
        else if (pulse_q[1]) state_d = ST_STEP;
        else if (run_lvl)    state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pulse_q[0])    state_d = ST_LOAD;
        else if (!run_lvl) state_d = ST_HALT;
        else begin
          cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
          cpu_en_d = (cnt_q == CNT_MAX);
        end
      end
      default: state_d = ST_HALT;
    endcase
    // Strobes are registered alongside the state they belong to.
    if (state_d == ST_STEP) cpu_en_d = 1'b1;
    if (state_d == ST_LOAD) begin
      pc_load_d = 1'b1;
      pc_val_d  = SYS_pc_val;
    end
  end

  always_comb begin
    snap_d    = '0;
    sel_err_d = 1'b1;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (SYS_output_sel == SEL_W'(k)) begin
        snap_d    = SYS_dbg[k*DATA_W +: DATA_W];
        sel_err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pulse_q   <= '0;
      state_q   <= ST_HALT;
      cnt_q     <= '0;
      cpu_en_q  <= 1'b0;
      pc_load_q <= 1'b0;
      pc_val_q  <= '0;
      snap_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sync1_q   <= {SYS_run, SYS_step, SYS_load};
      sync2_q   <= sync1_q;
      prev_q    <= {step_lvl, load_lvl};
      pulse_q   <= {step_lvl, load_lvl} & ~prev_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpu_en_q  <= cpu_en_d;
      pc_load_q <= pc_load_d;
      pc_val_q  <= pc_val_d;
      snap_q    <= snap_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign snap_ext = EXT_W'(snap_q);

  always_comb begin
    SYS_hex = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (i * 4 < DATA_W) SYS_hex[i*7 +: 7] = seg_hex(snap_ext[i*4 +: 4]);
      else                SYS_hex[i*7 +: 7] = SEG_BLANK;
    end
  end

  assign SYS_cpu_en      = cpu_en_q;
  assign SYS_pc_load     = pc_load_q;
  assign SYS_pc_load_val = pc_val_q;
  assign SYS_leds        = {state_q, sel_err_q, 3'b000};

endmodule

// File: tb/tb_sys_run_ctrl.sv
// Directed bench for sys_run_ctrl: a RUN_DIV=4 / 32-bit instance and a
// RUN_DIV=1 / 16-bit instance sharing clock and reset.
module tb_sys_run_ctrl;

`ifdef SYS_DEBOUNCE_EN
  localparam int unsigned LAT = 4 + 5;
`else
  localparam int unsigned LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0, step = 1'b0, run = 1'b0;
  logic [7:0]  pc_val = '0;
  logic [7:0]  sel = '0;
  logic [255:0] dbg = '0;
  logic        cpu_en, pc_load;
  logic [7:0]  pc_load_val, leds;
  logic [55:0] hex;

  logic        run16 = 1'b0;
  logic [7:0]  sel16 = '0;
  logic [127:0] dbg16 = '0;
  logic        cpu_en16, pc_load16;
  logic [7:0]  pc_load_val16, leds16;
  logic [55:0] hex16;

  int unsigned n_cmp = 0, n_bad = 0, viol = 0, ld_total = 0;

  always #5 clk = ~clk;

  sys_run_ctrl #(.RUN_DIV(4), .DEB_CYCLES(5)) u_dut (
    .SYS_clk(clk), .SYS_rst(rst), .SYS_load(load), .SYS_step(step), .SYS_run(run),
    .SYS_pc_val(pc_val), .SYS_output_sel(sel), .SYS_dbg(dbg),
    .SYS_cpu_en(cpu_en), .SYS_pc_load(pc_load), .SYS_pc_load_val(pc_load_val),
    .SYS_leds(leds), .SYS_hex(hex)
  );

  sys_run_ctrl #(.DATA_W(16), .RUN_DIV(1), .DEB_CYCLES(5)) u_dut16 (
    .SYS_clk(clk), .SYS_rst(rst), .SYS_load(1'b0), .SYS_step(1'b0), .SYS_run(run16),
    .SYS_pc_val(8'h00), .SYS_output_sel(sel16), .SYS_dbg(dbg16),
    .SYS_cpu_en(cpu_en16), .SYS_pc_load(pc_load16), .SYS_pc_load_val(pc_load_val16),
    .SYS_leds(leds16), .SYS_hex(hex16)
  );

  always @(negedge clk) begin
    if (cpu_en && pc_load) viol++;
    if (pc_load) ld_total++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller drives the key just after a posedge; k=0 is the following negedge.
  task automatic observe(input int unsigned ncyc, input int unsigned rel,
                         output int unsigned n_en, output int unsigned first_en,
                         output int unsigned n_ld, output int unsigned first_ld,
                         output logic [7:0] ld_val);
    n_en = 0; n_ld = 0; first_en = 999; first_ld = 999; ld_val = '0;
    for (int unsigned k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (cpu_en) begin
        if (n_en == 0) first_en = k;
        n_en++;
      end
      if (pc_load) begin
        if (n_ld == 0) first_ld = k;
        n_ld++;
        ld_val = pc_load_val;
      end
      if (k == rel) begin
        step = 1'b0;
        load = 1'b0;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n_en, first_en, n_ld, first_ld, last, gap_bad;
    logic [7:0] ld_val, led_a, led_b;
    logic       seen, pl;

    dbg[3*32 +: 32] = 32'h1234ABCD;
    dbg16[0 +: 16]  = 16'hBEEF;
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_en", cpu_en, 0);
    check_eq("rst_pc_load", pc_load, 0);
    check_eq("rst_pc_val", pc_load_val, 0);
    check_eq("rst_leds", leds, 8'h10);
    check_eq("rst_hex", hex, {8{7'h40}});
    check_eq("rst_hex16", hex16, {{4{7'h7F}}, {4{7'h40}}});
    rst = 1'b0;
    idle(4);

    // Display: 1-cycle latency, then full 8-digit decode.
    sel = 8'd3;
    @(negedge clk);
    check_eq("disp_latency_old", hex, {8{7'h40}});
    @(negedge clk);
    check_eq("disp_ch3", hex, {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
    check_eq("disp_digit0", hex[6:0], 7'h21);
    check_eq("disp_digit7", hex[55:49], 7'h79);
    @(posedge clk); #1 sel = 8'd200;
    repeat (2) @(negedge clk);
    check_eq("disp_sel_err_hex", hex, {8{7'h40}});
    check_eq("disp_sel_err_leds", leds, 8'h18);
    check_eq("disp16_beef", hex16, {{4{7'h7F}}, 7'h03, 7'h06, 7'h06, 7'h0E});
    @(posedge clk); #1 sel = 8'd3;
    idle(3);

    // Step held ~10 cycles gives one cpu_en at LAT.
    step = 1'b1;
    observe(24, 9, n_en, first_en, n_ld, first_ld, ld_val);
    check_eq("step_count", n_en, 1);
    check_eq("step_latency", first_en, LAT);
    check_eq("step_no_load", n_ld, 0);
    check_eq("step_back_halt", leds, 8'h10);
    idle(LAT + 4);

    // Load with simultaneous step: load wins, step dropped.
    pc_val = 8'hA5;
    load = 1'b1; step = 1'b1;
    observe(24, 9, n_en, first_en, n_ld, first_ld, ld_val);
    check_eq("load_count", n_ld, 1);
    check_eq("load_latency", first_ld, LAT);
    check_eq("load_val", ld_val, 8'hA5);
    check_eq("load_step_dropped", n_en, 0);
    check_eq("load_val_held", pc_load_val, 8'hA5);
    idle(LAT + 4);

    // RUN with RUN_DIV=4: entry at k=3, pulses at k=7,11,...,43.
    run = 1'b1;
    n_en = 0; first_en = 999; gap_bad = 0; last = 0; led_a = '0;
    for (int unsigned k = 0; k < 47; k++) begin
      @(negedge clk);
      if (k == 5) led_a = leds;
      if (cpu_en) begin
        if (n_en == 0) first_en = k;
        else if (k - last != 4) gap_bad++;
        last = k;
        n_en++;
      end
    end
    check_eq("run_leds", led_a, 8'h80);
    check_eq("run_count", n_en, 10);
    check_eq("run_first", first_en, 7);
    check_eq("run_spacing", gap_bad, 0);
    @(posedge clk); #1 run = 1'b0;
    repeat (3) @(negedge clk);
    led_a = leds;
    @(negedge clk);
    check_eq("run_drop_still_run", led_a, 8'h80);
    check_eq("run_drop_halt", leds, 8'h10);
    idle(4);

    // Load during RUN: LOAD then HALT.
    run = 1'b1;
    idle(10);
    load = 1'b1;
    led_a = '0; led_b = '0; pl = 1'b0;
    for (int unsigned k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == LAT) begin led_a = leds; pl = pc_load; end
      if (k == LAT + 1) led_b = leds;
    end
    check_eq("runload_state", led_a, 8'h40);
    check_eq("runload_strobe", pl, 1'b1);
    check_eq("runload_halt", led_b, 8'h10);
    run = 1'b0; load = 1'b0;
    idle(LAT + 6);

    // Async reset mid-RUN while cpu_en is high.
    run = 1'b1;
    seen = 1'b0;
    for (int unsigned k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (cpu_en) seen = 1'b1;
    end
    check_eq("rst_mid_found_pulse", seen, 1'b1);
    #1 rst = 1'b1; run = 1'b0;
    #1;
    check_eq("rst_mid_cpu_en", cpu_en, 0);
    check_eq("rst_mid_leds", leds, 8'h10);
    check_eq("rst_mid_hex", hex, {8{7'h40}});
    idle(2);
    rst = 1'b0;
    n_en = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_en) n_en++;
    end
    check_eq("rst_mid_stay_halt", leds, 8'h10);
    check_eq("rst_mid_no_en", n_en, 0);

    // RUN_DIV=1 on the 16-bit instance: cpu_en every cycle from k=4.
    @(posedge clk); #1 run16 = 1'b1;
    n_en = 0; first_en = 999;
    for (int unsigned k = 0; k < 14; k++) begin
      @(negedge clk);
      if (cpu_en16) begin
        if (n_en == 0) first_en = k;
        n_en++;
      end
    end
    check_eq("run1_count", n_en, 10);
    check_eq("run1_first", first_en, 4);
    run16 = 1'b0;
    idle(6);

`ifdef SYS_DEBOUNCE_EN
    // Bouncing load key, then stable 1: one pulse LAT cycles after settling.
    last = ld_total;
    for (int unsigned j = 0; j < 8; j++) begin
      load = (j % 2 == 0);
      idle(1);
    end
    load = 1'b1;
    observe(25, 24, n_en, first_en, n_ld, first_ld, ld_val);
    check_eq("deb_single_pulse", ld_total - last, 1);
    check_eq("deb_latency", first_ld, LAT);
    idle(LAT + 4);
`endif

    check_eq("excl_en_load", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
